ycbcr422_to_444: RTL and testbench
==================================

// Module: ycbcr422_to_444
// PURPOSE
//  Chroma upsampler sitting directly upstream of the YCbCr->RGB converter.
//  Accepts an interleaved 4:2:2 byte stream (Cb Y0 Cr Y1 ...) and emits one
//  4:4:4 pixel {y,cb,cr} per valid strobe, ready for the colour-space stage.
//  Odd pixels take either replicated or interpolated chroma (see CONFIGURATION).
// PARAMETERS
//  DATA_W   8   width of every sample (din, y, cb, cr)
// PORTS
//  clk        in   1       single clock, all logic rising-edge
//  rst_n      in   1       asynchronous, active-low reset
//  din        in   DATA_W  4:2:2 byte stream sample
//  din_valid  in   1       din qualifier; no backpressure, may be high every cycle
//  din_sol    in   1       with din_valid: byte is first Cb of a line
//  din_eol    in   1       with din_valid: byte is last Y1 of a line
//  y,cb,cr    out  DATA_W  4:4:4 pixel
//  dout_valid out  1       one-cycle pixel strobe
//  dout_sol   out  1       with dout_valid: first pixel of line
//  dout_eol   out  1       with dout_valid: last pixel of line
//  sync_err   out  1       one-cycle pulse on framing violation
// BEHAVIOUR
//  - Reset: all outputs 0, phase=CB, no pending pixel, holding regs 0.
//  - Phase counter CB->Y0->CR->Y1->CB advances only on din_valid.
//    din_sol forces byte to be taken as Cb (phase CB); if phase was not CB,
//    pulse sync_err, drop any pending pixel, restart line.
//  - din_eol on a non-Y1 byte: ignored as eol, sync_err pulsed.
//  - All outputs registered; output cycle = accept cycle + 1.
//  - Without interpolation: even pixel (Y0,Cb,Cr) out after Cr accepted;
//    odd pixel (Y1,Cb,Cr) out after Y1 accepted.
//  - With interpolation: even pixel k out after Y1_k accepted (odd k held
//    pending); odd pixel k-1 out after Cr_k accepted with
//    cb=(Cb_{k-1}+Cb_k+1)>>1, cr likewise (DATA_W+1 sum, round half up).
//    On Y1 with din_eol: even k at +1, then odd k at +2 in a FLUSH cycle
//    with replicated chroma; a Cb accepted in FLUSH is handled normally
//    (Cb never emits, so no output collision).
//  - At most one dout_valid per cycle; pixel order strictly preserved.
//  - dout_sol on first pixel after din_sol; dout_eol on pixel derived from
//    the eol Y1 (odd pixel of last group).
//  - din_valid low stalls everything; pending pixel held indefinitely.
//  - Line with single group: both pixels use that group's chroma.
// CONFIGURATION
//  CHROMA_INTERP_EN defined: odd-pixel chroma is averaged as above.
//  Undefined: odd pixel replicates co-sited chroma, no pending state or FLUSH.
// STRUCTURE
//  Shared package ycbcr_pkg: phase enum {CB,Y0,CR,Y1}, DATA_W default,
//  rounding-average function. One sub-module natural: chroma_avg2
//  (registered-free rounding average of two samples), instanced for Cb and Cr.
// TESTING
//  Stimulus line, back-to-back bytes cycles 0-7: Cb100 Y50 Cr200 Y60
//  Cb120 Y70 Cr180 Y80(eol), sol at cycle 0.
//  1 No interp: pixels (50,100,200)@3 sol,(60,100,200)@4,(70,120,180)@7,
//    (80,120,180)@8 eol.
//  2 Interp: (50,100,200)@4 sol,(60,110,190)@7,(70,120,180)@8,
//    (80,120,180)@9 eol.
//  3 Rounding, interp: Cb 101 then 102 -> odd cb=102; Cr 0 then 255 -> 128.
//  4 Stall: din_valid low 5 cycles between every byte -> same pixel values,
//    no extra or lost strobes.
//  5 sol at phase CR -> sync_err pulse, pending dropped, next line correct.
//  6 Reset asserted mid-line -> outputs 0 immediately; clean line after.

Source files
------------

// File: rtl/ycbcr_pkg.sv
// ycbcr_pkg: shared types and helpers for the 4:2:2 -> 4:4:4 chroma upsampler.
//   DATA_W_DEF : default sample width
//   phase_e    : position of the current byte inside a Cb Y0 Cr Y1 group
//   rnd_avg    : rounding average (a+b+1)>>1, computed one bit wider than the
//                operands so the carry is kept
package ycbcr_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {PH_CB, PH_Y0, PH_CR, PH_Y1} phase_e;

  function automatic logic [31:0] rnd_avg(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b} + 33'd1;
    return 32'(s >> 1);
  endfunction

endpackage

// File: rtl/chroma_avg2.sv
// chroma_avg2: combinational rounding average of two chroma samples.
//   i_a, i_b : DATA_W samples
//   o_avg    : (i_a + i_b + 1) >> 1, round half up
module chroma_avg2 import ycbcr_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_avg
);

  assign o_avg = DATA_W'(rnd_avg(32'(i_a), 32'(i_b)));

endmodule

// File: rtl/ycbcr422_to_444.sv
// ycbcr422_to_444: chroma upsampler, interleaved 4:2:2 (Cb Y0 Cr Y1 ...) to
// one {y,cb,cr} pixel per strobe. All outputs registered, one cycle after the
// accepting byte.
//   i_clk, i_rst_n (async, active low)
//   i_din / i_din_valid / i_din_sol / i_din_eol : input byte stream
//   o_y, o_cb, o_cr / o_dout_valid / o_dout_sol / o_dout_eol : output pixel
//   o_sync_err : one-cycle pulse on framing violation
// Build option: CHROMA_INTERP_EN -- odd pixels get chroma averaged with the
// next group; the odd pixel is held pending and, at end of line, flushed in a
// dedicated cycle with replicated chroma. Undefined: odd pixels replicate.
module ycbcr422_to_444 import ycbcr_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_din_valid,
  input  logic              i_din_sol,
  input  logic              i_din_eol,
  output logic [DATA_W-1:0] o_y,
  output logic [DATA_W-1:0] o_cb,
  output logic [DATA_W-1:0] o_cr,
  output logic              o_dout_valid,
  output logic              o_dout_sol,
  output logic              o_dout_eol,
  output logic              o_sync_err
);

  phase_e r_phase, w_phase_nxt, w_byte_ph;
  logic              w_sol, w_eol, w_err;
  logic [DATA_W-1:0] r_cb, r_y0, r_cr;
  logic              r_sol_pend;
  logic              w_emit, w_even, w_oeol;
  logic [DATA_W-1:0] w_y, w_cb, w_cr;

  // Phase tracking; a sol byte is always taken as Cb.
  always_comb begin
    w_sol       = i_din_valid & i_din_sol;
    w_byte_ph   = w_sol ? PH_CB : r_phase;
    w_phase_nxt = r_phase;
    if (i_din_valid) begin
      case (w_byte_ph)
        PH_CB:   w_phase_nxt = PH_Y0;
        PH_Y0:   w_phase_nxt = PH_CR;
        PH_CR:   w_phase_nxt = PH_Y1;
        default: w_phase_nxt = PH_CB;
      endcase
    end
    w_eol = i_din_valid & i_din_eol & (w_byte_ph == PH_Y1);
    w_err = (w_sol & (r_phase != PH_CB)) |
            (i_din_valid & i_din_eol & (w_byte_ph != PH_Y1));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_phase <= PH_CB;
    else          r_phase <= w_phase_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cb <= '0; r_y0 <= '0; r_cr <= '0;
    end else if (i_din_valid) begin
      case (w_byte_ph)
        PH_CB:   r_cb <= i_din;
        PH_Y0:   r_y0 <= i_din;
        PH_CR:   r_cr <= i_din;
        default: ;
      endcase
    end
  end

  // sol marks the next even pixel; Cb bytes never emit, so set/clear never collide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_sol_pend <= 1'b0;
    else if (w_sol)  r_sol_pend <= 1'b1;
    else if (w_even) r_sol_pend <= 1'b0;
  end

`ifdef CHROMA_INTERP_EN
  logic              r_pend_vld, r_flush;
  logic [DATA_W-1:0] r_pend_y, r_pend_cb, r_pend_cr;
  logic [DATA_W-1:0] w_cb_avg, w_cr_avg;

  // Odd pixel k-1 blends its own chroma with group k's (Cb_k already held, Cr_k on the bus).
  chroma_avg2 #(.DATA_W(DATA_W)) u_avg_cb (.i_a(r_pend_cb), .i_b(r_cb),  .o_avg(w_cb_avg));
  chroma_avg2 #(.DATA_W(DATA_W)) u_avg_cr (.i_a(r_pend_cr), .i_b(i_din), .o_avg(w_cr_avg));

  // Flush only occurs in phase CB, so it can never coincide with a Y1 or Cr emission.
  always_comb begin
    w_emit = 1'b0; w_even = 1'b0; w_oeol = 1'b0;
    w_y = r_y0; w_cb = r_cb; w_cr = r_cr;
    if (r_flush) begin
      w_emit = 1'b1; w_oeol = 1'b1;
      w_y = r_pend_y; w_cb = r_pend_cb; w_cr = r_pend_cr;
    end else if (i_din_valid && w_byte_ph == PH_Y1) begin
      w_emit = 1'b1; w_even = 1'b1;
    end else if (i_din_valid && w_byte_ph == PH_CR && r_pend_vld) begin
      w_emit = 1'b1;
      w_y = r_pend_y; w_cb = w_cb_avg; w_cr = w_cr_avg;
    end
  end

  // Any sol discards a leftover odd pixel (a flush in the same cycle still emits it).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_vld <= 1'b0; r_flush <= 1'b0;
      r_pend_y <= '0; r_pend_cb <= '0; r_pend_cr <= '0;
    end else if (i_din_valid && w_byte_ph == PH_Y1) begin
      r_pend_vld <= 1'b1; r_flush <= w_eol;
      r_pend_y <= i_din; r_pend_cb <= r_cb; r_pend_cr <= r_cr;
    end else if (w_emit || w_sol) begin
      r_pend_vld <= 1'b0; r_flush <= 1'b0;
    end
  end
`else
  always_comb begin
    w_emit = 1'b0; w_even = 1'b0; w_oeol = 1'b0;
    w_y = r_y0; w_cb = r_cb; w_cr = i_din;
    if (i_din_valid && w_byte_ph == PH_CR) begin
      w_emit = 1'b1; w_even = 1'b1;
    end else if (i_din_valid && w_byte_ph == PH_Y1) begin
      w_emit = 1'b1; w_oeol = w_eol;
      w_y = i_din; w_cr = r_cr;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_y <= '0; o_cb <= '0; o_cr <= '0;
      o_dout_valid <= 1'b0; o_dout_sol <= 1'b0; o_dout_eol <= 1'b0; o_sync_err <= 1'b0;
    end else begin
      o_dout_valid <= w_emit;
      o_dout_sol   <= w_even & r_sol_pend;
      o_dout_eol   <= w_oeol;
      o_sync_err   <= w_err;
      if (w_emit) begin
        o_y <= w_y; o_cb <= w_cb; o_cr <= w_cr;
      end
    end
  end

endmodule

// File: tb/tb_ycbcr422_to_444.sv
// Directed bench for ycbcr422_to_444; expectations follow the build
// (CHROMA_INTERP_EN defined or not). Pixel times are relative to the cycle the
// first byte of the line is presented.
module tb_ycbcr422_to_444;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       dv = 1'b0, dsol = 1'b0, deol = 1'b0;
  logic [7:0] y, cb, cr;
  logic       ov, osol, oeol, serr;

  ycbcr422_to_444 #(.DATA_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_din(din), .i_din_valid(dv),
    .i_din_sol(dsol), .i_din_eol(deol),
    .o_y(y), .o_cb(cb), .o_cr(cr), .o_dout_valid(ov),
    .o_dout_sol(osol), .o_dout_eol(oeol), .o_sync_err(serr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; int y; int cb; int cr; int f; } pix_t;
  pix_t mon_q[$], exp_q[$];
  int   err_t[$];
  int   base = 0;
  bit   mark = 1'b0;
  int   n_chk = 0, n_pass = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov)   mon_q.push_back('{t: cyc - base, y: int'(y), cb: int'(cb), cr: int'(cr),
                                  f: int'({osol, oeol})});
      if (serr) err_t.push_back(cyc - base);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int B(input int v, input int s, input int e);
    return v | (s << 8) | (e << 9);
  endfunction

  task automatic ep(input int t, input int yy, input int cbv, input int crv, input int s, input int e);
    exp_q.push_back('{t: t, y: yy, cb: cbv, cr: crv, f: (s << 1) | e});
  endtask

  task automatic send(input int v);
    @(negedge clk);
    din = 8'(v); dv = 1'b1; dsol = v[8]; deol = v[9];
    if (mark) begin base = cyc; mark = 1'b0; end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    dv = 1'b0; dsol = 1'b0; deol = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic line_start();
    mon_q.delete(); exp_q.delete(); err_t.delete();
    mark = 1'b1;
  endtask

  task automatic send_seq(input int q[$], input int gap);
    for (int i = 0; i < q.size(); i++) begin
      send(q[i]);
      if (gap > 0 && i < q.size() - 1) idle(gap);
    end
    idle(8);
  endtask

  task automatic check_pix(input string nm, input bit chk_t);
    chk({nm, " count"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      if (chk_t) chk($sformatf("%s p%0d time", nm, i), mon_q[i].t, exp_q[i].t);
      chk($sformatf("%s p%0d y", nm, i),        mon_q[i].y,  exp_q[i].y);
      chk($sformatf("%s p%0d cb", nm, i),       mon_q[i].cb, exp_q[i].cb);
      chk($sformatf("%s p%0d cr", nm, i),       mon_q[i].cr, exp_q[i].cr);
      chk($sformatf("%s p%0d sol/eol", nm, i),  mon_q[i].f,  exp_q[i].f);
    end
  endtask

  task automatic exp_line_a();
`ifdef CHROMA_INTERP_EN
    ep(4, 50, 100, 200, 1, 0); ep(7, 60, 110, 190, 0, 0);
    ep(8, 70, 120, 180, 0, 0); ep(9, 80, 120, 180, 0, 1);
`else
    ep(3, 50, 100, 200, 1, 0); ep(4, 60, 100, 200, 0, 0);
    ep(7, 70, 120, 180, 0, 0); ep(8, 80, 120, 180, 0, 1);
`endif
  endtask

  int line_a[$];

  initial begin
    line_a = '{B(100,1,0), 50, 200, 60, 120, 70, 180, B(80,0,1)};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset outputs", int'({y, cb, cr, ov, osol, oeol, serr}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic line, back-to-back
    line_start(); exp_line_a(); send_seq(line_a, 0);
    check_pix("line", 1'b1);
    chk("line sync_err count", err_t.size(), 0);

    // rounding: (101+102+1)>>1 = 102, (0+255+1)>>1 = 128
    line_start();
`ifdef CHROMA_INTERP_EN
    ep(4, 10, 101, 0, 1, 0);   ep(7, 11, 102, 128, 0, 0);
    ep(8, 12, 102, 255, 0, 0); ep(9, 13, 102, 255, 0, 1);
`else
    ep(3, 10, 101, 0, 1, 0);   ep(4, 11, 101, 0, 0, 0);
    ep(7, 12, 102, 255, 0, 0); ep(8, 13, 102, 255, 0, 1);
`endif
    send_seq('{B(101,1,0), 10, 0, 11, 102, 12, 255, B(13,0,1)}, 0);
    check_pix("round", 1'b1);

    // 5 idle cycles between every byte: same pixels, no extra strobes
    line_start(); exp_line_a(); send_seq(line_a, 5);
    check_pix("stall", 1'b0);

    // sol arriving at phase CR: error, partial group and pending dropped
    line_start();
`ifdef CHROMA_INTERP_EN
    ep(4, 50, 100, 200, 1, 0); ep(10, 31, 30, 40, 1, 0); ep(11, 32, 30, 40, 0, 1);
`else
    ep(3, 50, 100, 200, 1, 0); ep(4, 60, 100, 200, 0, 0);
    ep(9, 31, 30, 40, 1, 0);   ep(10, 32, 30, 40, 0, 1);
`endif
    send_seq('{B(100,1,0), 50, 200, 60, 120, 70, B(30,1,0), 31, 40, B(32,0,1)}, 0);
    check_pix("solerr", 1'b1);
    chk("solerr sync_err count", err_t.size(), 1);
    if (err_t.size() > 0) chk("solerr sync_err time", err_t[0], 7);

    // eol on a Y0 byte is an error and ignored; single-group line
    line_start();
`ifdef CHROMA_INTERP_EN
    ep(4, 50, 100, 200, 1, 0); ep(5, 60, 100, 200, 0, 1);
`else
    ep(3, 50, 100, 200, 1, 0); ep(4, 60, 100, 200, 0, 1);
`endif
    send_seq('{B(100,1,0), B(50,0,1), 200, B(60,0,1)}, 0);
    check_pix("eolerr", 1'b1);
    chk("eolerr sync_err count", err_t.size(), 1);
    if (err_t.size() > 0) chk("eolerr sync_err time", err_t[0], 2);

    // reset mid-line while a pixel is on the output
    line_start();
    send(B(100,1,0)); send(50); send(200); send(60);
    @(negedge clk); dv = 1'b0; dsol = 1'b0; deol = 1'b0;
    chk("pre-reset valid", int'(ov), 1);
    #1 rst_n = 1'b0;
    #1 chk("async reset outputs", int'({y, cb, cr, ov, osol, oeol, serr}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    line_start(); exp_line_a(); send_seq(line_a, 0);
    check_pix("postrst", 1'b1);
    chk("postrst sync_err count", err_t.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
